// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: default widths, opcode values
// and the stage state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial-product step per clock,
// WIDTH steps per multiply. 'done' is high during the step that finishes,
// and 'product' already includes that step, so the caller can capture it
// on the same edge.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [CW-1:0]    count;

    assign acc_nx  = mplier[0] ? (acc + mcand) : acc;
    assign done    = busy && (count == LAST);
    assign product = acc_nx;

    // Load operands on start, then add/shift once per cycle until the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (count == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle ALU ops, iterative multiply,
// valid/ready handshakes on both sides and registered Result/flags.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [OPW-1:0]   Opcode,
    input  logic [WIDTH-1:0] Source1,
    input  logic [WIDTH-1:0] Source2,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             is_mul;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign In_ready  = (state == S_IDLE);
    assign Out_valid = (state == S_DONE);
    assign accept    = In_valid && In_ready;
    assign is_mul    = (Opcode == OPW'(OP_MUL));
    assign shamt     = Source2[SW-1:0];
    assign sum       = Source1 + Source2;
    assign diff      = Source1 - Source2;

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (accept && is_mul),
        .multiplicand (Source1),
        .multiplier   (Source2),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    // Single-cycle operations, evaluated on the live operands at acceptance.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (Opcode)
            OPW'(OP_ADD): begin
                alu_res = sum;
                alu_ovf = (Source1[WIDTH-1] == Source2[WIDTH-1]) &&
                          (sum[WIDTH-1] != Source1[WIDTH-1]);
            end
            OPW'(OP_SUB): begin
                alu_res = diff;
                alu_ovf = (Source1[WIDTH-1] != Source2[WIDTH-1]) &&
                          (diff[WIDTH-1] != Source1[WIDTH-1]);
            end
            OPW'(OP_AND):  alu_res = Source1 & Source2;
            OPW'(OP_OR):   alu_res = Source1 | Source2;
            OPW'(OP_XOR):  alu_res = Source1 ^ Source2;
            OPW'(OP_NOR):  alu_res = ~(Source1 | Source2);
            OPW'(OP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, ($signed(Source1) < $signed(Source2))};
            OPW'(OP_SLTU): alu_res = {{(WIDTH-1){1'b0}}, (Source1 < Source2)};
            OPW'(OP_SLL):  alu_res = Source1 << shamt;
            OPW'(OP_SRL):  alu_res = Source1 >> shamt;
            OPW'(OP_SRA):  alu_res = $signed(Source1) >>> shamt;
            OPW'(OP_MUL):  alu_res = '0;
            default:       alu_ill = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a result must be consumed before the next op can be accepted.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = is_mul ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (mul_busy && mul_done) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (Out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Capture Result and flags once per operation; they hold through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result   <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            Illegal  <= 1'b0;
        end else if ((state == S_IDLE) && accept && !is_mul) begin
            Result   <= alu_res;
            Zero     <= (alu_res == '0);
            Overflow <= alu_ovf;
            Illegal  <= alu_ill;
        end else if ((state == S_EXEC) && mul_busy && mul_done) begin
            Result   <= mul_product;
            Zero     <= (mul_product == '0);
            Overflow <= 1'b0;
            Illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases plus random operations, checked
// against an arithmetic reference model of the opcode rules.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [3:0]  Opcode = '0;
    logic [31:0] Source1 = '0;
    logic [31:0] Source2 = '0;
    logic        Out_valid;
    logic        Out_ready = 1'b0;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        Illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Opcode    (Opcode),
        .Source1   (Source1),
        .Source2   (Source2),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .Illegal   (Illegal)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Safety net in case the stage stops responding altogether.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: result and flags from plain signed/unsigned arithmetic.
    function automatic void modelOp(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic ovf, output logic ill);
        longint sa, sb, s;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            4'd0: begin
                s = sa + sb;
                r = a + b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                s = sa - sb;
                r = a - b;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: begin
                s = sa >>> b[4:0];
                r = s[31:0];
            end
            4'd11: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0];
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation, check latency, result, hold under backpressure and consume.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int stall);
        logic [31:0] expRes;
        logic        expOvf;
        logic        expIll;
        int          waits;
        logic        readySeen;
        modelOp(op, a, b, expRes, expOvf, expIll);
        @(negedge clk);
        checkOutput("in_ready_idle", {31'b0, In_ready}, 32'd1);
        Opcode    = op;
        Source1   = a;
        Source2   = b;
        In_valid  = 1'b1;
        Out_ready = (stall == 0);
        @(posedge clk);
        #1;
        In_valid = 1'b0;
        Opcode   = 4'($urandom);
        Source1  = $urandom;
        Source2  = $urandom;
        waits     = 0;
        readySeen = 1'b0;
        @(negedge clk);
        while (!Out_valid && waits < 40) begin
            if (In_ready) readySeen = 1'b1;
            waits++;
            @(negedge clk);
        end
        checkOutput("latency", waits, (op == OP_MUL) ? 32'd32 : 32'd0);
        checkOutput("in_ready_busy", {31'b0, readySeen}, 32'd0);
        checkOutput("result", Result, expRes);
        checkOutput("zero", {31'b0, Zero}, {31'b0, (expRes == 32'd0)});
        checkOutput("overflow", {31'b0, Overflow}, {31'b0, expOvf});
        checkOutput("illegal", {31'b0, Illegal}, {31'b0, expIll});
        checkOutput("in_ready_done", {31'b0, In_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            In_valid = 1'b1;
            Source1  = $urandom;
            @(negedge clk);
            checkOutput("hold_result", Result, expRes);
            checkOutput("hold_valid", {31'b0, Out_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'b0, In_ready}, 32'd0);
        end
        Out_ready = 1'b1;
        In_valid  = 1'b1;
        @(negedge clk);
        checkOutput("consumed_valid", {31'b0, Out_valid}, 32'd0);
        checkOutput("consumed_in_ready", {31'b0, In_ready}, 32'd1);
        In_valid  = 1'b0;
        Out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Directed sequence, mid-multiply reset, then random operations.
    initial begin
        #12;
        checkOutput("rst_in_ready", {31'b0, In_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, Out_valid}, 32'd0);
        checkOutput("rst_result", Result, 32'd0);
        checkOutput("rst_zero", {31'b0, Zero}, 32'd0);
        checkOutput("rst_overflow", {31'b0, Overflow}, 32'd0);
        checkOutput("rst_illegal", {31'b0, Illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_ADD, 32'd21, 32'd444, 0);
        applyStimulus(OP_SUB, 32'd21, 32'd444, 0);
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
        applyStimulus(OP_SUB, 32'd1, 32'd1, 0);
        applyStimulus(OP_SUB, 32'h8000_0000, 32'd1, 1);
        applyStimulus(OP_MUL, 32'd1000, 32'd2000, 0);
        applyStimulus(OP_MUL, 32'hFFFF_FFFF, 32'd3, 2);
        applyStimulus(OP_SRA, 32'h8000_0000, 32'd4, 0);
        applyStimulus(OP_SRL, 32'h8000_0000, 32'd4, 0);
        applyStimulus(OP_SLL, 32'h0000_0003, 32'd33, 0);
        applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus(OP_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 0);
        applyStimulus(OP_ADD, 32'd3456, 32'd1234, 5);
        applyStimulus(4'd13, 32'd55, 32'd66, 0);

        // Leave a nonzero Result with Overflow set, then abort a multiply.
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
        @(negedge clk);
        Opcode   = OP_MUL;
        Source1  = 32'd12345;
        Source2  = 32'd678;
        In_valid = 1'b1;
        @(posedge clk);
        #1;
        In_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", {31'b0, In_ready}, 32'd1);
        checkOutput("abort_out_valid", {31'b0, Out_valid}, 32'd0);
        checkOutput("abort_result", Result, 32'd0);
        checkOutput("abort_zero", {31'b0, Zero}, 32'd0);
        checkOutput("abort_overflow", {31'b0, Overflow}, 32'd0);
        checkOutput("abort_illegal", {31'b0, Illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_abort_in_ready", {31'b0, In_ready}, 32'd1);
        checkOutput("post_abort_out_valid", {31'b0, Out_valid}, 32'd0);
        applyStimulus(OP_ADD, 32'd100, 32'd23, 0);
        applyStimulus(OP_MUL, 32'd7, 32'd9, 0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand(),
                          int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execute stage that consumes the two operand values produced by the register-file read stage (Source1/Source2) plus an opcode. It produces a 32-bit result with Zero/Overflow/Illegal flags.
- Single-cycle logic/arithmetic/shift ops.
- Iterative 32-step shift-add multiply.
- Valid/ready handshake on both input and output.
It sits between register-file read and the result consumer/writeback.

Parameters:
WIDTH, 32, operand/result width (shift amount uses low $clog2(WIDTH) bits of Source2)
OPW, 4, opcode width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
In_valid  input  1  operands/opcode valid
In_ready  output  1  stage can accept an operation
Opcode  input  OPW  operation select
Source1  input  WIDTH  operand A from register-file read port 1
Source2  input  WIDTH  operand B from register-file read port 2
Out_valid  output  1  result valid
Out_ready  input  1  consumer accepts result
Result  output  WIDTH  operation result
Zero  output  1  Result == 0
Overflow  output  1  signed overflow (ADD/SUB only)
Illegal  output  1  opcode 12..15 was issued

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, In_ready=1, Out_valid=0, Result=0, Zero=0, Overflow=0, Illegal=0, multiplier count=0.
- Handshake:
  - An operation is accepted on the rising edge where In_valid && In_ready.
  - Opcode, Source1 and Source2 are sampled only at acceptance; later changes are ignored.
  - A result is consumed on the edge where Out_valid && Out_ready.
- State machine IDLE / EXEC / DONE:
  - In_ready = (state==IDLE).
  - IDLE, accept with Opcode==MUL: load multiplicand, multiplier, accumulator=0, count=0; go to EXEC.
  - IDLE, accept with any other opcode: compute result combinationally and register Result/flags; go to DONE. Latency is 1 cycle (Out_valid high after the accepting edge).
  - EXEC: each edge, if multiplier LSB is 1 then accumulator += multiplicand; then shift multiplicand left 1, shift multiplier right 1, count++. On the edge with count==WIDTH-1, the final accumulator goes to Result and the stage goes to DONE. MUL latency is exactly WIDTH (32) edges after acceptance.
  - DONE: Out_valid=1. Result and flags are held stable while Out_ready=0 (unbounded backpressure). On the consume edge, go to IDLE and Out_valid=0.
  - Throughput: at most one operation per 2 cycles. No accept is possible in DONE, even if Out_ready=1 that cycle.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed, result 1/0.
  - 7 SLTU: unsigned, result 1/0.
  - 8 SLL, 9 SRL, 10 SRA: shift Source1 by Source2[4:0].
  - 11 MUL: low WIDTH bits of the unsigned product, equal to low WIDTH bits of the signed product.
  - 12..15: Result=0, Illegal=1, 1-cycle latency.
- Width/flag rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow = operand signs (B inverted for SUB) agree and result sign differs; Overflow=0 for all other ops.
  - Zero is computed from the registered Result.
  - Illegal=0 for legal opcodes.
- Reset mid-operation: rst_n low in EXEC or DONE aborts immediately. All outputs return to reset values asynchronously, and the partial product is discarded.
- Simultaneous In_valid and Out_ready in DONE: the result is consumed and the new operation is not accepted; the new operation is accepted next cycle in IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL);
  - state encoding typedef (IDLE, EXEC, DONE);
  - default WIDTH/OPW constants.
- One sub-module alu_seq_mul, the iterative shift-add multiplier.
  - Ports: start, operands, busy/done, product.
  - alu_exec_stage instantiates it and owns the FSM and handshakes.

Test Plan:
- ADD 21+444, Out_ready=1 -> Out_valid one cycle after accept, Result=465 (0x1D1), Zero=0, Overflow=0, then In_ready=1 the following cycle.
- SUB 21-444 -> Result=0xFFFFFE59; ADD 0x7FFFFFFF+1 -> Result=0x80000000, Overflow=1; SUB 1-1 -> Result=0, Zero=1.
- MUL 1000*2000 -> In_ready=0 and Out_valid=0 for 32 edges, Out_valid after edge 32, Result=0x001E8480; MUL 0xFFFFFFFF*3 -> 0xFFFFFFFD.
- Shifts/compares: SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
- Backpressure: ADD 3456+1234 with Out_ready=0 for 5 cycles -> Result=4690 stable, Out_valid=1, In_ready=0 and In_valid ignored throughout; consumed on the first Out_ready=1 cycle.
- Opcode 13 -> Result=0, Illegal=1. rst_n pulsed low mid-MUL (count 10) -> outputs at reset values immediately, In_ready=1 after release, next ADD correct.
